// File: rtl/toe_conn_requester.sv
// Avalon-MM master for the TOE connection-init slave: writes the tuple, polls done, reads error/id, clears done.
// Build option TOE_CONN_TIMEOUT_EN bounds polling to POLL_MAX reads and reports a timeout response.
module toe_conn_requester #(
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_ip_src_i,
  input  logic [31:0] req_ip_dst_i,
  input  logic [23:0] req_mac_src_i,
  input  logic [23:0] req_mac_dst_i,
  input  logic [15:0] req_port_src_i,
  input  logic [15:0] req_port_dst_i,
  input  logic [7:0]  req_id_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [7:0]  rsp_error_o,
  output logic [7:0]  rsp_id_o,
  output logic        rsp_timeout_o,
  output logic [3:0]  avm_address_o,
  output logic        avm_chipselect_o,
  output logic        avm_write_o,
  output logic [31:0] avm_writedata_o,
  output logic        avm_read_o,
  input  logic [31:0] avm_readdata_i
);

  typedef enum logic [3:0] {
    IDLE, WR, POLL_RD, POLL_CHK, GAP, ERR_RD, ERR_CHK, ID_RD, ID_CHK, CLR, RESP
  } state_e;

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_e        state_q, state_d;
  logic [2:0]    wcnt_q, wcnt_d, wnext;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_error_q, rsp_error_d;
  logic [7:0]    rsp_id_q, rsp_id_d;
  logic          rsp_to_q, rsp_to_d;
  logic [3:0]    addr_q, addr_d;
  logic          wr_q, wr_d, rd_q, rd_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          accept, timed_out;

  logic [1:0]    op_q;
  logic [31:0]   ip_dst_q;
  logic [23:0]   mac_src_q, mac_dst_q;
  logic [15:0]   port_src_q, port_dst_q;
  logic [7:0]    id_q;

`ifdef TOE_CONN_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_MAX + 1);
  logic [PCW-1:0] pcnt_q, pcnt_d;
`endif

  logic unused_bits;
  assign unused_bits = (^avm_readdata_i[31:8]) ^ (POLL_MAX > 0);

  assign accept = req_valid_i && req_ready_q;

  // ip_src goes straight onto the bus in the accept cycle, so it is never stored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q       <= '0;
      ip_dst_q   <= '0;
      mac_src_q  <= '0;
      mac_dst_q  <= '0;
      port_src_q <= '0;
      port_dst_q <= '0;
      id_q       <= '0;
    end else if (accept) begin
      op_q       <= req_op_i;
      ip_dst_q   <= req_ip_dst_i;
      mac_src_q  <= req_mac_src_i;
      mac_dst_q  <= req_mac_dst_i;
      port_src_q <= req_port_src_i;
      port_dst_q <= req_port_dst_i;
      id_q       <= req_id_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      gcnt_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= '0;
      rsp_id_q    <= '0;
      rsp_to_q    <= 1'b0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      wdata_q     <= '0;
`ifdef TOE_CONN_TIMEOUT_EN
      pcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      gcnt_q      <= gcnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_id_q    <= rsp_id_d;
      rsp_to_q    <= rsp_to_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
`ifdef TOE_CONN_TIMEOUT_EN
      pcnt_q      <= pcnt_d;
`endif
    end
  end

  // Bus strobes are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    gcnt_d      = gcnt_q;
    wnext       = wcnt_q + 3'd1;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_id_d    = rsp_id_q;
    rsp_to_d    = rsp_to_q;
    addr_d      = '0;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    wdata_d     = '0;
    timed_out   = 1'b0;
`ifdef TOE_CONN_TIMEOUT_EN
    pcnt_d      = pcnt_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          rsp_error_d = '0;
          rsp_id_d    = '0;
          rsp_to_d    = 1'b0;
`ifdef TOE_CONN_TIMEOUT_EN
          pcnt_d      = '0;
`endif
          if (req_op_i == 2'b01 || req_op_i == 2'b10) begin
            state_d = WR;
            wcnt_d  = '0;
            wr_d    = 1'b1;
            addr_d  = 4'h3;
            wdata_d = req_ip_src_i;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 8'hFE;
          end
        end
      end
      WR: begin
        if (wcnt_q == 3'd7) begin
          state_d = POLL_RD;
          rd_d    = 1'b1;
          addr_d  = 4'h1;
        end else begin
          wcnt_d = wnext;
          wr_d   = 1'b1;
          case (wnext)
            3'd1:    begin addr_d = 4'h4; wdata_d = ip_dst_q;              end
            3'd2:    begin addr_d = 4'h5; wdata_d = {8'h00, mac_src_q};    end
            3'd3:    begin addr_d = 4'h6; wdata_d = {8'h00, mac_dst_q};    end
            3'd4:    begin addr_d = 4'h7; wdata_d = {16'h0000, port_src_q}; end
            3'd5:    begin addr_d = 4'h8; wdata_d = {16'h0000, port_dst_q}; end
            3'd6:    begin addr_d = 4'hA; wdata_d = {24'h0, id_q};          end
            default: begin addr_d = 4'h0; wdata_d = {30'h0, op_q};          end
          endcase
        end
      end
      POLL_RD: state_d = POLL_CHK;
      POLL_CHK: begin
        if (avm_readdata_i[0]) begin
          state_d = ERR_RD;
          rd_d    = 1'b1;
          addr_d  = 4'h2;
        end else begin
`ifdef TOE_CONN_TIMEOUT_EN
          pcnt_d    = pcnt_q + 1'b1;
          timed_out = (pcnt_d == PCW'(POLL_MAX));
`endif
          if (timed_out) begin
            state_d     = CLR;
            wr_d        = 1'b1;
            addr_d      = 4'h1;
            rsp_to_d    = 1'b1;
            rsp_error_d = 8'hFF;
            rsp_id_d    = '0;
          end else if (POLL_GAP == 0) begin
            state_d = POLL_RD;
            rd_d    = 1'b1;
            addr_d  = 4'h1;
          end else begin
            state_d = GAP;
            gcnt_d  = '0;
          end
        end
      end
      GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = POLL_RD;
          rd_d    = 1'b1;
          addr_d  = 4'h1;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      ERR_RD: state_d = ERR_CHK;
      ERR_CHK: begin
        rsp_error_d = avm_readdata_i[7:0];
        state_d     = ID_RD;
        rd_d        = 1'b1;
        addr_d      = 4'h9;
      end
      ID_RD: state_d = ID_CHK;
      ID_CHK: begin
        rsp_id_d = avm_readdata_i[7:0];
        state_d  = CLR;
        wr_d     = 1'b1;
        addr_d   = 4'h1;
      end
      CLR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o      = req_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_error_o      = rsp_error_q;
  assign rsp_id_o         = rsp_id_q;
  assign rsp_timeout_o    = rsp_to_q;
  assign avm_address_o    = addr_q;
  assign avm_write_o      = wr_q;
  assign avm_read_o       = rd_q;
  assign avm_chipselect_o = wr_q | rd_q;
  assign avm_writedata_o  = wdata_q;

endmodule

// File: tb/tb_toe_conn_requester.sv
// Directed bench for toe_conn_requester with a latency-1 register slave model and bus logger.
module tb_toe_conn_requester;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [31:0] req_ip_src = '0, req_ip_dst = '0;
  logic [23:0] req_mac_src = '0, req_mac_dst = '0;
  logic [15:0] req_port_src = '0, req_port_dst = '0;
  logic [7:0]  req_id = '0;
  logic        rsp_ready = 1'b1;
  logic [31:0] rdata = '0;
  logic        req_ready, rsp_valid, rsp_timeout;
  logic [7:0]  rsp_error, rsp_id;
  logic [3:0]  avm_address;
  logic        avm_cs, avm_write, avm_read;
  logic [31:0] avm_wdata;

  int checks = 0, errors = 0, cyc = 0, bad_strobe = 0;
  int poll_n = 0, poll_base = 0, done_at = 1;
  logic [7:0] err_val = '0, id_val = '0;
  logic [3:0]  wa[$], ra[$];
  logic [31:0] wd[$];
  int          wc[$], rc[$];

  toe_conn_requester #(.POLL_GAP(4), .POLL_MAX(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_ip_src_i(req_ip_src), .req_ip_dst_i(req_ip_dst),
    .req_mac_src_i(req_mac_src), .req_mac_dst_i(req_mac_dst),
    .req_port_src_i(req_port_src), .req_port_dst_i(req_port_dst),
    .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_error_o(rsp_error),
    .rsp_id_o(rsp_id), .rsp_timeout_o(rsp_timeout),
    .avm_address_o(avm_address), .avm_chipselect_o(avm_cs), .avm_write_o(avm_write),
    .avm_writedata_o(avm_wdata), .avm_read_o(avm_read), .avm_readdata_i(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: read data appears the cycle after the strobe; garbage otherwise.
  always @(posedge clk) begin
    if (avm_read) begin
      case (avm_address)
        4'h1: begin
          rdata  <= {16'hC0DE, 15'h0,
                     (done_at != 0) && ((poll_n - poll_base + 1) >= done_at)};
          poll_n <= poll_n + 1;
        end
        4'h2:    rdata <= {24'hC0FFEE, err_val};
        4'h9:    rdata <= {24'hBEEF00, id_val};
        default: rdata <= 32'h0;
      endcase
    end else begin
      rdata <= 32'h5A5A5A5A;
    end
  end

  always @(negedge clk) begin
    if (avm_write) begin wa.push_back(avm_address); wd.push_back(avm_wdata); wc.push_back(cyc); end
    if (avm_read)  begin ra.push_back(avm_address); rc.push_back(cyc); end
    if ((avm_read && avm_write) || (avm_cs != (avm_read | avm_write))) bad_strobe++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); ra.delete(); rc.delete();
    poll_base = poll_n;
  endtask

  task automatic scramble();
    req_op = 2'($urandom); req_ip_src = $urandom; req_ip_dst = $urandom;
    req_mac_src = 24'($urandom); req_mac_dst = 24'($urandom);
    req_port_src = 16'($urandom); req_port_dst = 16'($urandom); req_id = 8'($urandom);
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] s, input logic [31:0] d,
                       input logic [23:0] ms, input logic [23:0] md,
                       input logic [15:0] ps, input logic [15:0] pd, input logic [7:0] id);
    req_op = op; req_ip_src = s; req_ip_dst = d; req_mac_src = ms; req_mac_dst = md;
    req_port_src = ps; req_port_dst = pd; req_id = id; req_valid = 1'b1;
  endtask

  // Called at a negedge with the request already driven; returns the accept cycle.
  task automatic accept_req(output int t0);
    t0 = -1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin t0 = cyc; break; end
      @(negedge clk);
    end
    chk("req_accepted", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_rsp(output int t);
    t = -1;
    for (int i = 0; i < 500; i++) begin
      if (rsp_valid) begin t = cyc; break; end
      @(negedge clk);
    end
    chk("rsp_seen", {31'h0, rsp_valid}, 32'h1);
  endtask

  task automatic chk_writes(input string tag, input int from, input int t0, input logic [1:0] op,
                            input logic [31:0] s, input logic [31:0] d,
                            input logic [23:0] ms, input logic [23:0] md,
                            input logic [15:0] ps, input logic [15:0] pd, input logic [7:0] id);
    logic [3:0]  ea[8];
    logic [31:0] ed[8];
    ea = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'h0};
    ed = '{s, d, {8'h0, ms}, {8'h0, md}, {16'h0, ps}, {16'h0, pd}, {24'h0, id}, {30'h0, op}};
    chk({tag, "_wcount"}, 32'(wa.size() >= from + 8), 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wa[from+i]), 32'(ea[i]));
      chk($sformatf("%s_data%0d", tag, i), wd[from+i], ed[i]);
      chk($sformatf("%s_cyc%0d", tag, i), 32'(wc[from+i]), 32'(t0 + 1 + i));
    end
  endtask

  int t0, t1, tr, tb;

  initial begin
    scramble();
    req_op = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_avm", {28'h0, avm_write, avm_read, avm_cs, rsp_valid}, 32'h0);
    chk("rst_rsp", {15'h0, rsp_timeout, rsp_id, rsp_error}, 32'h0);
    chk("rst_addr_data", avm_wdata | {28'h0, avm_address}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

    // Open, done on first poll: minimum latency.
    clear_log(); done_at = 1; err_val = 8'h00; id_val = 8'h05; rsp_ready = 1'b1;
    drive(2'b01, 32'h0A000001, 32'h0A000002, 24'h123456, 24'hABCDEF, 16'd80, 16'd1234, 8'h00);
    accept_req(t0);
    wait_rsp(t1);
    chk("open_rsp_cycle", 32'(t1 - t0), 32'd16);
    chk("open_rsp_id", {24'h0, rsp_id}, 32'h05);
    chk("open_rsp_error", {24'h0, rsp_error}, 32'h00);
    chk("open_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
    @(negedge clk);
    chk_writes("open", 0, t0, 2'b01, 32'h0A000001, 32'h0A000002, 24'h123456, 24'hABCDEF,
               16'd80, 16'd1234, 8'h00);
    chk("open_wtotal", 32'(wa.size()), 32'd9);
    chk("open_clr", {wd[8][27:0], wa[8]}, 32'h1);
    chk("open_clr_cyc", 32'(wc[8] - t0), 32'd15);
    chk("open_reads", {20'h0, ra[0], ra[1], ra[2]}, 32'h129);
    chk("open_read_cyc", 32'((rc[0] - t0) * 256 + (rc[1] - t0) * 16 + (rc[2] - t0)), 32'h9BD);

    // Kill, done on third poll, POLL_GAP=4.
    repeat (2) @(negedge clk);
    clear_log(); done_at = 3; err_val = 8'h02; id_val = 8'h33;
    drive(2'b10, 32'hC0A80001, 32'hC0A80002, 24'h010203, 24'h040506, 16'd22, 16'd5555, 8'h07);
    accept_req(t0);
    wait_rsp(t1);
    chk("kill_rsp_cycle", 32'(t1 - t0), 32'd28);
    chk("kill_rsp_error", {24'h0, rsp_error}, 32'h02);
    chk("kill_rsp_id", {24'h0, rsp_id}, 32'h33);
    @(negedge clk);
    chk_writes("kill", 0, t0, 2'b10, 32'hC0A80001, 32'hC0A80002, 24'h010203, 24'h040506,
               16'd22, 16'd5555, 8'h07);
    chk("kill_nreads", 32'(ra.size()), 32'd5);
    chk("kill_poll_addrs", {20'h0, ra[0], ra[1], ra[2]}, 32'h111);
    chk("kill_poll_gap1", 32'(rc[1] - rc[0]), 32'd6);
    chk("kill_poll_gap2", 32'(rc[2] - rc[1]), 32'd6);
    chk("kill_first_poll", 32'(rc[0] - t0), 32'd9);

    // Invalid op: immediate local error, held under backpressure.
    repeat (2) @(negedge clk);
    clear_log(); rsp_ready = 1'b0;
    drive(2'b00, 32'h1, 32'h2, 24'h3, 24'h4, 16'h5, 16'h6, 8'h09);
    accept_req(t0);
    wait_rsp(t1);
    chk("inv_rsp_cycle", 32'(t1 - t0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("inv_hold%0d", i),
          {6'h0, req_ready, rsp_valid, rsp_timeout, 7'h0, rsp_id, rsp_error}, 32'h010000FE);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("inv_rsp_drop", {31'h0, rsp_valid}, 32'h0);
    chk("inv_no_bus", 32'(wa.size() + ra.size()), 32'd0);

    // Polling limit: POLL_MAX=3.
    repeat (2) @(negedge clk);
    clear_log(); err_val = 8'h11; id_val = 8'h22;
`ifdef TOE_CONN_TIMEOUT_EN
    done_at = 0;
`else
    done_at = 5;
`endif
    drive(2'b01, 32'hAAAA0001, 32'hBBBB0002, 24'h111111, 24'h222222, 16'd1, 16'd2, 8'h44);
    accept_req(t0);
    wait_rsp(t1);
    @(negedge clk);
`ifdef TOE_CONN_TIMEOUT_EN
    chk("to_rsp_cycle", 32'(t1 - t0), 32'd24);
    chk("to_rsp", {15'h0, rsp_timeout, rsp_id, rsp_error}, 32'h000100FF);
    chk("to_npolls", 32'(ra.size()), 32'd3);
    chk("to_clr", {wd[8][27:0], wa[8]}, 32'h1);
    chk("to_clr_cyc", 32'(wc[8] - t0), 32'd23);
`else
    chk("nolim_rsp_cycle", 32'(t1 - t0), 32'd40);
    chk("nolim_rsp", {15'h0, rsp_timeout, rsp_id, rsp_error}, 32'h00002211);
    chk("nolim_nreads", 32'(ra.size()), 32'd7);
`endif

    // Asynchronous reset during write index 4.
    repeat (2) @(negedge clk);
    clear_log(); done_at = 1; err_val = 8'h00; id_val = 8'h06;
    drive(2'b01, 32'h01020304, 32'h05060708, 24'h0A0B0C, 24'h0D0E0F, 16'd7, 16'd8, 8'h01);
    accept_req(t0);
    for (int i = 0; i < 20 && cyc < t0 + 5; i++) @(negedge clk);
    chk("rst_mid_beat4", {27'h0, avm_write, avm_address}, 32'h17);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_avm", avm_wdata | {25'h0, avm_write, avm_read, avm_cs, avm_address}, 32'h0);
    chk("rst_mid_flags", {30'h0, rsp_valid, req_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_no_clr", 32'(wa.size()), 32'd5);
    clear_log();
    drive(2'b10, 32'h11112222, 32'h33334444, 24'h555555, 24'h666666, 16'd9, 16'd10, 8'h0B);
    accept_req(t0);
    wait_rsp(t1);
    chk("rst_next_rsp_cycle", 32'(t1 - t0), 32'd16);
    chk("rst_next_rsp_id", {24'h0, rsp_id}, 32'h06);
    @(negedge clk);
    chk_writes("rst_next", 0, t0, 2'b10, 32'h11112222, 32'h33334444, 24'h555555, 24'h666666,
               16'd9, 16'd10, 8'h0B);

    // Back-to-back with rsp_ready high; request B held on the inputs during A.
    repeat (2) @(negedge clk);
    clear_log(); done_at = 1; rsp_ready = 1'b1;
    drive(2'b01, 32'hA0000001, 32'hA0000002, 24'hA00003, 24'hA00004, 16'hA005, 16'hA006, 8'hA7);
    accept_req(t0);
    drive(2'b10, 32'hB0000001, 32'hB0000002, 24'hB00003, 24'hB00004, 16'hB005, 16'hB006, 8'hB7);
    tr = -1; tb = -1;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid && tr < 0) tr = cyc;
      if (req_ready) begin tb = cyc; break; end
      @(negedge clk);
    end
    chk("b2b_a_rsp", 32'(tr - t0), 32'd16);
    chk("b2b_b_accept", 32'(tb - t0), 32'd17);
    @(negedge clk);
    req_valid = 1'b0;
    scramble();
    wait_rsp(t1);
    chk("b2b_b_rsp", 32'(t1 - tb), 32'd16);
    @(negedge clk);
    chk_writes("b2b_a", 0, t0, 2'b01, 32'hA0000001, 32'hA0000002, 24'hA00003, 24'hA00004,
               16'hA005, 16'hA006, 8'hA7);
    chk_writes("b2b_b", 9, tb, 2'b10, 32'hB0000001, 32'hB0000002, 24'hB00003, 24'hB00004,
               16'hB005, 16'hB006, 8'hB7);

    chk("strobe_rules", 32'(bad_strobe), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/toe_conn_requester.md
# toe_conn_requester

Avalon-MM master that drives the TOE connection-init register slave on behalf of on-chip logic. It takes one connection request (open or kill) on a valid/ready handshake, writes the connection tuple and request code into the slave's register map, and polls the done flag. It then reads back the error code and the assigned connection id, clears done, and returns the result on a response handshake. It sits between the packet/control datapath and the TOE init block, replacing software polling.

## Interface
- POLL_GAP, 4: idle cycles between consecutive done polls (0 allowed).
- POLL_MAX, 1024: done polls before timeout; used only when the timeout feature is compiled in.
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  block idle and able to accept.
- req_op  in  2  2'b01 open, 2'b10 kill; other values invalid.
- req_ip_src, req_ip_dst  in  32  IPv4 addresses.
- req_mac_src, req_mac_dst  in  24  MAC fields.
- req_port_src, req_port_dst  in  16  TCP ports.
- req_id  in  8  connection id written to register A; used by kill.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  consumer accepts response.
- rsp_error  out  8  error register (2) contents, or a local code.
- rsp_id  out  8  id register (9) contents.
- rsp_timeout  out  1  done never seen within POLL_MAX polls.
- avm_address  out  4  slave word address.
- avm_chipselect  out  1  asserted together with read or write.
- avm_write  out  1  single-cycle write strobe.
- avm_writedata  out  32  write data; unused upper bits zero.
- avm_read  out  1  single-cycle read strobe.
- avm_readdata  in  32  valid exactly one cycle after avm_read (fixed latency 1, no waitrequest).

## Operation
- Accept when req_valid && req_ready; capture all req_* fields. req_ready is high only in IDLE.
- States: IDLE, WR, POLL_RD, POLL_CHK, GAP, ERR_RD, ERR_CHK, ID_RD, ID_CHK, CLR, RESP.
- WR: 3-bit counter issues 8 back-to-back writes, one per cycle, in the order addr 3 ip_src, 4 ip_dst, 5 mac_src, 6 mac_dst, 7 port_src, 8 port_dst, A id, 0 op. Narrow fields are zero-extended.
- POLL_RD: read addr 1. POLL_CHK samples readdata[0].
  - If 1: go to ERR_RD.
  - If 0: go to GAP for POLL_GAP cycles, then POLL_RD. With POLL_GAP=0, go directly to POLL_RD.
- ERR_RD/ERR_CHK: read addr 2, capture readdata[7:0] into rsp_error.
- ID_RD/ID_CHK: read addr 9, capture readdata[7:0] into rsp_id.
- CLR: write 0 to addr 1. Then RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready; on handshake go to IDLE.
- Invalid op (00/11): no bus activity; go straight to RESP with rsp_error=8'hFE, rsp_id=0, rsp_timeout=0.
- Never assert avm_read and avm_write in the same cycle. chipselect = read | write.

## Timing
- Reset values: req_ready=0 while rst is high and 1 in IDLE afterwards; all avm_* outputs 0; rsp_valid=0; rsp_error, rsp_id, rsp_timeout=0; state IDLE; all counters 0.
- Reset mid-transaction aborts immediately; no clear write is issued and the pending request is dropped.
- With the handshake in cycle 0:
  - writes occur in cycles 1–8;
  - the first poll read is in cycle 9 and is sampled in cycle 10.
- If done is seen on the first poll: error read in cycle 11, id read in cycle 13, clear write in cycle 15, rsp_valid in cycle 16. This is the minimum latency.
- Each extra poll adds 2+POLL_GAP cycles.
- A new request is accepted no earlier than the cycle after the rsp handshake.
- All outputs are registered.

## Configuration
- TOE_CONN_TIMEOUT_EN defined: a poll counter (width clog2(POLL_MAX+1)) increments at each POLL_CHK that samples 0.
  - When the count reaches POLL_MAX: skip ERR/ID reads, perform the CLR write, then RESP with rsp_timeout=1, rsp_error=8'hFF, rsp_id=0.
- TOE_CONN_TIMEOUT_EN undefined: polling is unbounded, rsp_timeout is tied to 0, and POLL_MAX is ignored.

## Test plan
- Open request ip_src=0x0A000001, ip_dst=0x0A000002, mac_src=0x123456, mac_dst=0xABCDEF, ports 80/1234, id 0x00; slave model returns done=1 on the first poll, error=0, id=0x05.
  - Check writes in order 3,4,5,6,7,8,A,0 with exact data, 0x1 at addr 0, and the clear write of 0 at addr 1.
  - Check rsp_valid at cycle 16 with rsp_id=0x05, rsp_error=0.
- Kill request op=10, id=0x07; done on the 3rd poll, POLL_GAP=4, error=0x02.
  - Check addr 0 written with 0x2, three reads of addr 1 spaced 6 cycles apart, rsp_error=0x02.
- Invalid op=00: no avm strobes; rsp_error=0xFE one cycle after accept. Hold rsp_ready low for 5 cycles and check outputs stay stable.
- Timeout build with POLL_MAX=3, done never set: exactly 3 polls, then the clear write; rsp_timeout=1, rsp_error=0xFF.
- Assert rst asynchronously during write index 4: all avm_* outputs drop to 0 immediately, req_ready returns after reset, and the next request runs from addr 3.
- Back-to-back requests with rsp_ready tied high: the second is accepted the cycle after the first response, and captured fields are not corrupted by req_* changes during a transaction.
